// File: rtl/posit_processing_unit.sv
// Posit adder: returns the correctly rounded posit sum of two posit operands, registered.
//
// Parameters
//   N   posit word width (4..32)
//   es  exponent field width (0..N-3)
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset (out=0, inf=0, zero=1)
//   in1    posit operand A
//   in2    posit operand B
//   out    registered posit sum A+B
//   inf    out is NaR (1 followed by zeros)
//   zero   out is all zeros
// Configuration
//   PPU_INPUT_REG_EN  when defined, operands pass through an input register stage (latency 2)
module posit_processing_unit #(
  parameter int unsigned N  = 5,
  parameter int unsigned es = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic [N-1:0] out,
  output logic         inf,
  output logic         zero
);

  // W: aligned-mantissa width; carry bit, N-bit mantissa, N+2 bits for shifted-out precision.
  localparam int unsigned W   = 2 * N + 3;
  localparam int unsigned SW  = $clog2(N) + es + 3;
  localparam int unsigned ESW = (es > 0) ? es : 1;
  localparam int unsigned DW  = $clog2(W + 1);
  localparam int unsigned LW  = 2 + ESW + (W - 1) + N;

  localparam logic signed [SW-1:0] One  = SW'(1);
  localparam logic signed [SW-1:0] KMax = SW'(N - 2);
  localparam logic signed [SW-1:0] KMin = -SW'(N - 1);
  localparam logic signed [SW-1:0] WLim = SW'(W);
  localparam logic [N-1:0] NaR    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MaxPos = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MinPos = N'(1);

  typedef struct packed {
    logic                 sgn;
    logic signed [SW-1:0] scale;
    logic [N-1:0]         mant;   // 1.f with hidden bit at MSB
  } dec_t;

  function automatic dec_t decode(input logic [N-1:0] x);
    dec_t                 d;
    logic [N-2:0]         body, run, tmp, frac;
    logic                 r0;
    int unsigned          m;
    logic signed [SW-1:0] ms, k;
    logic [ESW-1:0]       e;
    d.sgn = x[N-1];
    body  = x[N-1] ? (N-1)'(-x) : x[N-2:0];
    r0    = body[N-2];
    // Regime length = leading zeros of the run after inverting a ones-run.
    run   = r0 ? ~body : body;
    m     = N - 1;
    for (int i = 0; i < N - 1; i++) begin
      if (run[i]) m = N - 2 - i;
    end
    tmp    = body << (m + 1);
    e      = (es > 0) ? tmp[N-2 -: ESW] : '0;
    frac   = tmp << es;
    ms     = SW'(m);
    k      = r0 ? (ms - One) : -ms;
    d.scale = (k <<< es) + $signed({{(SW-ESW){1'b0}}, e});
    d.mant  = {1'b1, frac};
    return d;
  endfunction

  logic [N-1:0] op_a, op_b;

`ifdef PPU_INPUT_REG_EN
  logic [N-1:0] a_q, b_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= in1;
      b_q <= in2;
    end
  end
  assign op_a = a_q;
  assign op_b = b_q;
`else
  assign op_a = in1;
  assign op_b = in2;
`endif

  dec_t                 da, db, big, sml;
  logic signed [SW-1:0] diff, lzs, res_scale, kr;
  logic [SW-1:0]        rr;
  logic [DW-1:0]        shamt;
  logic [W-1:0]         big_ext, sml_ext, mask, aligned, sum;
  logic                 sticky, guard, rsticky, rnd;
  int unsigned          lz;
  logic [W-2:0]         frac_r;
  logic [ESW-1:0]       er;
  logic [1:0]           pat;
  logic signed [LW-1:0] v, vs;
  logic [N-2:0]         top;
  logic [N-1:0]         rsum, mag, out_d, out_q;

  always_comb begin
    da = decode(op_a);
    db = decode(op_b);
    if (($signed(db.scale) > $signed(da.scale)) ||
        (($signed(db.scale) == $signed(da.scale)) && (db.mant > da.mant))) begin
      big = db;
      sml = da;
    end else begin
      big = da;
      sml = db;
    end

    // Align the smaller mantissa; everything shifted out is jammed into the LSB.
    diff    = $signed(big.scale) - $signed(sml.scale);
    shamt   = (diff >= WLim) ? DW'(W) : diff[DW-1:0];
    big_ext = {1'b0, big.mant, {(W-1-N){1'b0}}};
    sml_ext = {1'b0, sml.mant, {(W-1-N){1'b0}}};
    mask    = ~({W{1'b1}} << shamt);
    sticky  = |(sml_ext & mask);
    aligned = (sml_ext >> shamt) | W'(sticky);
    sum     = (big.sgn == sml.sgn) ? (big_ext + aligned) : (big_ext - aligned);

    lz = W;
    for (int i = 0; i < W; i++) begin
      if (sum[i]) lz = W - 1 - i;
    end
    lzs       = SW'(lz);
    res_scale = $signed(big.scale) + One - lzs;
    frac_r    = (W-1)'(sum << lz);

    // Build regime|exponent|fraction as one bit string, then round it to N-1 bits.
    kr  = res_scale >>> es;
    er  = res_scale[ESW-1:0];
    rr  = (kr >= 0) ? kr : (-kr - One);
    pat = (kr >= 0) ? 2'b10 : 2'b01;
    v   = (es > 0) ? {pat, er, frac_r, {N{1'b0}}} : {pat, frac_r, {(N+1){1'b0}}};
    vs  = v >>> rr;
    top     = vs[LW-1 -: N-1];
    guard   = vs[LW-N];
    rsticky = |vs[LW-N-1:0];
    rnd     = guard & (rsticky | top[0]);
    rsum    = {1'b0, top} + N'(rnd);

    if (kr > KMax)        mag = MaxPos;
    else if (kr < KMin)   mag = MinPos;
    else if (rsum[N-1])   mag = MaxPos;
    else if (rsum == '0)  mag = MinPos;
    else                  mag = rsum;

    if ((op_a == NaR) || (op_b == NaR)) out_d = NaR;
    else if (op_a == '0)                out_d = op_b;
    else if (op_b == '0)                out_d = op_a;
    else if (sum == '0)                 out_d = '0;
    else                                out_d = big.sgn ? -mag : mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out  = out_q;
  assign inf  = (out_q == NaR);
  assign zero = (out_q == '0);

endmodule

// File: tb/tb_posit_processing_unit.sv
module tb_posit_processing_unit;

`ifdef PPU_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] in1 = '0;
  logic [4:0] in2 = '0;
  logic [4:0] out;
  logic       inf;
  logic       zero;

  int total = 0;
  int bad   = 0;

  posit_processing_unit #(.N(5), .es(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in1   (in1),
    .in2   (in2),
    .out   (out),
    .inf   (inf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got out/inf/zero=%b want %b", name, got, exp);
    end
  endtask

  // Real value of an n-bit posit with es=1.
  function automatic real pval(input int unsigned p, input int n);
    int unsigned x;
    int          i, m, k, e, sc;
    bit          s, r0;
    real         f, fb, v;
    if (p == 0) return 0.0;
    s = ((p >> (n - 1)) & 1) != 0;
    x = s ? ((1 << n) - p) : p;
    i = n - 2;
    r0 = ((x >> i) & 1) != 0;
    m = 0;
    while (i >= 0 && ((((x >> i) & 1) != 0) == r0)) begin
      m++;
      i--;
    end
    i--;
    k = r0 ? m - 1 : -m;
    e = 0;
    if (i >= 0) begin
      e = int'((x >> i) & 1);
      i--;
    end
    f = 1.0;
    fb = 0.5;
    while (i >= 0) begin
      if (((x >> i) & 1) != 0) f += fb;
      fb = fb / 2.0;
      i--;
    end
    sc = 2 * k + e;
    v = f;
    for (int j = 0; j < sc; j++) v = v * 2.0;
    for (int j = 0; j < -sc; j++) v = v / 2.0;
    return s ? -v : v;
  endfunction

  // Exact real sum, rounded in posit order: the midpoint between adjacent
  // 5-bit posits q and q+1 is the 6-bit posit {q,1}; ties go to even q.
  function automatic logic [4:0] model_add(input logic [4:0] a, input logic [4:0] b);
    real         x, ax, lo, hi, mid;
    int unsigned mag;
    if (a == 5'b10000 || b == 5'b10000) return 5'b10000;
    if (a == 5'b0) return b;
    if (b == 5'b0) return a;
    x = pval(a, 5) + pval(b, 5);
    if (x == 0.0) return 5'b0;
    ax = (x < 0.0) ? -x : x;
    mag = 1;
    if (ax >= pval(15, 5)) mag = 15;
    else if (ax <= pval(1, 5)) mag = 1;
    else begin
      for (int q = 1; q < 15; q++) begin
        lo = pval(q, 5);
        hi = pval(q + 1, 5);
        if (ax >= lo && ax < hi) begin
          mid = pval(2 * q + 1, 6);
          if (ax < mid) mag = q;
          else if (ax > mid) mag = q + 1;
          else mag = (q % 2 == 0) ? q : q + 1;
        end
      end
    end
    return (x < 0.0) ? 5'((32 - mag) % 32) : 5'(mag);
  endfunction

  function automatic logic [6:0] pack(input logic [4:0] r);
    return {r, r == 5'b10000, r == 5'b0};
  endfunction

  // Per-cycle compare against the model, delayed by the pipeline latency.
  logic [6:0] pipe_exp [2];
  bit         pipe_v   [2];

  always @(posedge clk) begin
    logic [6:0] cur_e;
    bit         cur_v;
    cur_v = rst_n;
    cur_e = pack(model_add(in1, in2));
    #1;
    pipe_exp[1] = pipe_exp[0];
    pipe_v[1]   = pipe_v[0];
    pipe_exp[0] = cur_e;
    pipe_v[0]   = cur_v;
    if (!rst_n) begin
      pipe_v[0] = 1'b0;
      pipe_v[1] = 1'b0;
    end
    if (pipe_v[LAT-1]) check("stream", {out, inf, zero}, pipe_exp[LAT-1]);
  end

  logic [4:0] va [11] = '{5'b01000, 5'b01000, 5'b00001, 5'b10000, 5'b01111, 5'b10001,
                          5'b01010, 5'b01000, 5'b11000, 5'b00110, 5'b01000};
  logic [4:0] vb [11] = '{5'b01000, 5'b11000, 5'b00000, 5'b01011, 5'b01111, 5'b10001,
                          5'b00110, 5'b00101, 5'b11000, 5'b00110, 5'b11010};
  logic [4:0] ve [11] = '{5'b01010, 5'b00000, 5'b00001, 5'b10000, 5'b01111, 5'b10001,
                          5'b01010, 5'b01001, 5'b10110, 5'b01000, 5'b00110};

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", {out, inf, zero}, 7'b0000001);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      check("model_pin", {2'b00, model_add(va[i], vb[i])}, {2'b00, ve[i]});
      @(negedge clk);
      in1 = va[i];
      in2 = vb[i];
      repeat (LAT) @(posedge clk);
      #2;
      check("directed", {out, inf, zero}, pack(ve[i]));
    end

    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        @(negedge clk);
        in1 = 5'(a);
        in2 = 5'(b);
      end
    end

    // Asynchronous reset mid-stream while a nonzero result is held.
    @(negedge clk);
    in1 = 5'b01000;
    in2 = 5'b01000;
    repeat (LAT) @(posedge clk);
    #3;
    check("pre_reset", {out, inf, zero}, 7'b0101000);
    rst_n = 1'b0;
    #1;
    check("async_reset", {out, inf, zero}, 7'b0000001);
    @(negedge clk);
    check("held_reset", {out, inf, zero}, 7'b0000001);
    rst_n = 1'b1;
    in1 = 5'b01000;
    in2 = 5'b01000;
    @(posedge clk);
    #1;
    check("first_after_release", {out, inf, zero},
          (LAT == 1) ? 7'b0101000 : 7'b0000001);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in1 = va[i];
      in2 = vb[i];
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
